// File: rtl/pc_seq_pkg.sv
// Shared opcodes, FSM state encoding and the default program image for the program sequencer.
package pc_seq_pkg;

   localparam logic [2:0] OPC_ADD = 3'b000;
   localparam logic [2:0] OPC_SUB = 3'b001;
   localparam logic [2:0] OPC_MUL = 3'b010;
   localparam logic [2:0] OPC_BRZ = 3'b100;
   localparam logic [2:0] OPC_HLT = 3'b101;
   localparam logic [2:0] OPC_LDI = 3'b110;
   localparam logic [2:0] OPC_JMP = 3'b111;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } seq_state_t;

   // LDI R0,5 ; ADD 1 x3 ; JMP 1 -- an endless accumulate loop
   function automatic logic [7:0] default_prog(input logic [31:0] addr);
      logic [7:0] word;
      case (addr)
         32'd0:                word = 8'hC5;
         32'd1, 32'd2, 32'd3:  word = 8'h01;
         32'd4:                word = 8'hE1;
         default:              word = 8'h00;
      endcase
      return word;
   endfunction

endpackage

// File: rtl/pc_seq_store.sv
// Program store with combinational read. Default build: constant ROM.
// With PC_SEQ_PROG_LOAD_EN: writable array reloaded with the default program on reset.
module pc_seq_store
   import pc_seq_pkg::*;
#(
   parameter int IW    = 8,
   parameter int AW    = 4,
   parameter int DEPTH = 16
) (
`ifdef PC_SEQ_PROG_LOAD_EN
   input  logic          clock,
   input  logic          reset,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [IW-1:0] prog_data,
`endif
   input  logic [AW-1:0] rd_addr,
   output logic [IW-1:0] rd_data
);

`ifdef PC_SEQ_PROG_LOAD_EN
   logic [IW-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= IW'(default_prog(32'(i)));
      end else if (prog_we && (32'(prog_addr) < DEPTH)) begin
         mem[prog_addr] <= prog_data;
      end
   end

   always_comb begin
      rd_data = '0;
      if (32'(rd_addr) < DEPTH) rd_data = mem[rd_addr];
   end
`else
   always_comb begin
      rd_data = '0;
      if (32'(rd_addr) < DEPTH) rd_data = IW'(default_prog(32'(rd_addr)));
   end
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: pc, JMP/BRZ/HLT control flow and valid/ready presentation.
// Optional PC_SEQ_PROG_LOAD_EN adds a program-load write port into the store.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  ST_RUN  | fetching whenever ena and the output slot is free
//  ST_HALT | HLT fetched; pc frozen until restart or reset
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int IW        = 8,
   parameter int AW        = 4,
   parameter int DEPTH     = 16,
   parameter int LAST_ADDR = DEPTH - 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          ena,
   input  logic          restart,
   input  logic          zero_flag,
   input  logic          instr_ready,
`ifdef PC_SEQ_PROG_LOAD_EN
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [IW-1:0] prog_data,
`endif
   output logic [IW-1:0] instr_out,
   output logic          instr_valid,
   output logic          halted,
   output logic [AW-1:0] pc_out
);

   seq_state_t    state;
   logic [AW-1:0] pc;
   logic [AW-1:0] seq_pc;
   logic [AW-1:0] next_pc;
   logic [IW-1:0] fetch_word;
   logic [2:0]    opc;
   logic          fetch;

   pc_seq_store #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) u_store (
`ifdef PC_SEQ_PROG_LOAD_EN
      .clock     (clock),
      .reset     (reset),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
`endif
      .rd_addr   (pc),
      .rd_data   (fetch_word)
   );

   always_comb begin
      opc     = fetch_word[IW-1:IW-3];
      seq_pc  = (pc == AW'(LAST_ADDR)) ? '0 : pc + 1'b1;
      next_pc = seq_pc;
      case (opc)
         OPC_JMP: next_pc = fetch_word[AW-1:0];
         OPC_BRZ: if (zero_flag) next_pc = fetch_word[AW-1:0];
         default: next_pc = seq_pc;
      endcase
      fetch = (state == ST_RUN) && ena && (!instr_valid || instr_ready);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_RUN;
         pc          <= '0;
         instr_out   <= '0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
         pc_out      <= '0;
      end else if (restart) begin
         // a pending word is dropped; instr_out/pc_out keep stale contents under valid=0
         state       <= ST_RUN;
         pc          <= '0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
      end else if (fetch) begin
         instr_out   <= fetch_word;
         pc_out      <= pc;
         instr_valid <= 1'b1;
         pc          <= next_pc;
         if (opc == OPC_HLT) begin
            state  <= ST_HALT;
            halted <= 1'b1;
         end
      end else if (instr_valid && instr_ready) begin
         instr_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer; program-load cases run when PC_SEQ_PROG_LOAD_EN is defined.
module tb_pc_sequencer;

   localparam int IW = 8;
   localparam int AW = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          ena;
   logic          restart;
   logic          zero_flag;
   logic          instr_ready;
   logic [IW-1:0] instr_out;
   logic          instr_valid;
   logic          halted;
   logic [AW-1:0] pc_out;
`ifdef PC_SEQ_PROG_LOAD_EN
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [IW-1:0] prog_data;
`endif

   int vec_cnt     = 0;
   int miscmp_cnt  = 0;
   logic [IW+AW-1:0] exp_q [$];
   int n;

   pc_sequencer #(.IW(IW), .AW(AW), .DEPTH(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .ena         (ena),
      .restart     (restart),
      .zero_flag   (zero_flag),
      .instr_ready (instr_ready),
`ifdef PC_SEQ_PROG_LOAD_EN
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
`endif
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .halted      (halted),
      .pc_out      (pc_out)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         miscmp_cnt++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push(input logic [IW-1:0] w, input logic [AW-1:0] p);
      exp_q.push_back({w, p});
   endtask

   // pops the scoreboard for a word that transfers at the coming edge, then advances one cycle
   task automatic clk_step();
      logic [IW+AW-1:0] e;
      if (!reset && !restart && instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_xfer", {20'd0, instr_out, pc_out}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check_val("xfer_instr", 32'(instr_out), 32'(e[IW+AW-1:AW]));
            check_val("xfer_pc", 32'(pc_out), 32'(e[AW-1:0]));
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic drain(input int budget, output int steps);
      steps = 0;
      while (exp_q.size() != 0 && steps < budget) begin
         clk_step();
         steps++;
      end
      if (exp_q.size() != 0) check_val("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic do_restart();
      restart = 1'b1;
      clk_step();
      restart = 1'b0;
   endtask

`ifdef PC_SEQ_PROG_LOAD_EN
   task automatic prog_write(input logic [AW-1:0] a, input logic [IW-1:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      clk_step();
      prog_we   = 1'b0;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; ena = 1'b0; restart = 1'b0; zero_flag = 1'b0; instr_ready = 1'b0;
`ifdef PC_SEQ_PROG_LOAD_EN
      prog_we = 1'b0; prog_addr = '0; prog_data = '0;
`endif
      repeat (3) clk_step();
      check_val("rst_instr", 32'(instr_out), 0);
      check_val("rst_valid", 32'(instr_valid), 0);
      check_val("rst_halted", 32'(halted), 0);
      check_val("rst_pc", 32'(pc_out), 0);

      reset = 1'b0;
      repeat (2) clk_step();
      check_val("ena0_no_fetch", 32'(instr_valid), 0);

      // free-running default program, JMP loops back to 1
      ena = 1'b1; instr_ready = 1'b1;
      push(8'hC5, 0); push(8'h01, 1); push(8'h01, 2); push(8'h01, 3); push(8'hE1, 4);
      push(8'h01, 1); push(8'h01, 2); push(8'h01, 3); push(8'hE1, 4);
      drain(30, n);
      check_val("seq_len", n, 10);

      // back-pressure: hold for 3 cycles, then no bubble
      instr_ready = 1'b0;
      do_restart();
      check_val("restart_valid", 32'(instr_valid), 0);
      check_val("restart_halted", 32'(halted), 0);
      clk_step();
      for (int i = 0; i < 3; i++) begin
         check_val("stall_valid", 32'(instr_valid), 1);
         check_val("stall_instr", 32'(instr_out), 32'hC5);
         check_val("stall_pc", 32'(pc_out), 0);
         clk_step();
      end
      push(8'hC5, 0); push(8'h01, 1); push(8'h01, 2);
      instr_ready = 1'b1;
      drain(10, n);
      check_val("stall_no_bubble", n, 3);

      // ena low mid-run: pending word held until taken, then resume from saved pc
      do_restart();
      push(8'hC5, 0); push(8'h01, 1);
      drain(10, n);
      ena = 1'b0; instr_ready = 1'b0;
      repeat (2) begin
         clk_step();
         check_val("ena0_hold_valid", 32'(instr_valid), 1);
         check_val("ena0_hold_instr", 32'(instr_out), 32'h01);
         check_val("ena0_hold_pc", 32'(pc_out), 2);
      end
      instr_ready = 1'b1;
      push(8'h01, 2);
      clk_step();
      check_val("ena0_drop_valid", 32'(instr_valid), 0);
      clk_step();
      check_val("ena0_idle_valid", 32'(instr_valid), 0);
      ena = 1'b1;
      push(8'h01, 3); push(8'hE1, 4); push(8'h01, 1);
      drain(10, n);
      check_val("ena1_resume_len", n, 4);

      // restart while a word is pending discards it and refetches address 0
      instr_ready = 1'b0;
      do_restart();
      check_val("restart_discard", 32'(instr_valid), 0);
      clk_step();
      check_val("restart_fetch_valid", 32'(instr_valid), 1);
      check_val("restart_fetch_instr", 32'(instr_out), 32'hC5);
      check_val("restart_fetch_pc", 32'(pc_out), 0);

`ifdef PC_SEQ_PROG_LOAD_EN
      // BRZ 3 at address 0, taken
      ena = 1'b0;
      do_restart();
      prog_write(4'd0, 8'h83);
      do_restart();
      ena = 1'b1; instr_ready = 1'b1; zero_flag = 1'b1;
      push(8'h83, 0); push(8'h01, 3); push(8'hE1, 4); push(8'h01, 1);
      drain(20, n);

      // BRZ not taken
      ena = 1'b0; instr_ready = 1'b0; zero_flag = 1'b0;
      do_restart();
      ena = 1'b1; instr_ready = 1'b1;
      push(8'h83, 0); push(8'h01, 1); push(8'h01, 2);
      drain(20, n);

      // HLT at address 2
      ena = 1'b0; instr_ready = 1'b0;
      do_restart();
      prog_write(4'd2, 8'hA0);
      do_restart();
      ena = 1'b1; instr_ready = 1'b1;
      push(8'h83, 0); push(8'h01, 1); push(8'hA0, 2);
      drain(20, n);
      check_val("hlt_halted", 32'(halted), 1);
      check_val("hlt_valid", 32'(instr_valid), 0);
      repeat (3) begin
         clk_step();
         check_val("hlt_no_fetch", 32'(instr_valid), 0);
      end
      instr_ready = 1'b0;
      do_restart();
      check_val("hlt_restart_halted", 32'(halted), 0);
      clk_step();
      check_val("hlt_restart_valid", 32'(instr_valid), 1);
      check_val("hlt_restart_instr", 32'(instr_out), 32'h83);
      check_val("hlt_restart_pc", 32'(pc_out), 0);

      // reset reloads the image; overwrite address 1 and observe on two passes
      reset = 1'b1; ena = 1'b0;
      clk_step();
      reset = 1'b0;
      prog_write(4'd1, 8'h22);
      ena = 1'b1; instr_ready = 1'b1;
      push(8'hC5, 0); push(8'h22, 1); push(8'h01, 2); push(8'h01, 3); push(8'hE1, 4); push(8'h22, 1);
      drain(20, n);
      reset = 1'b1;
      clk_step();
      reset = 1'b0;
      push(8'hC5, 0); push(8'h01, 1);
      drain(10, n);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
      $finish;
   end

endmodule
